rr_select_encoder: RTL and testbench

Round-robin arbiter for four requesters that produces the registered 2-bit select code (gnt_code[1] -> I1, gnt_code[0] -> I0) feeding the 2x4 decoder stage, plus a qualifying gnt_valid. Sits directly upstream of the decoder. The decoder turns the code into one-hot enables, which the consumer gates with gnt_valid. Grants are held until released, the requester drops, or a programmable hold limit expires.

---
 rtl/rr_select_pkg.sv | 28 ++
 rtl/rr_select_encoder_if.sv | 41 ++++
 rtl/rr_select_encoder_pick.sv | 41 ++++
 rtl/rr_select_encoder.sv | 130 +++++++++++++
 tb/tb_rr_select_encoder.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/rr_select_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_select_pkg
// Description : Shared types and constants for the round-robin select
//               encoder: requester count, 2-bit grant code type, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_select_pkg;

    // Number of requesters arbitrated.
    localparam int N_REQ = 4;

    // Encoded grant index {I1,I0} feeding the 2x4 decoder.
    typedef logic [1:0] code_t;

    // Arbiter states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Next index in circular order; 3 wraps naturally to 0 in two bits.
    function automatic code_t code_inc(input code_t c);
        return c + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_select_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_select_encoder_if
// Description : Request/grant bundle between the requesters and the
//               round-robin select encoder.
//               req       : request vector, req[i] from requester i
//               rel       : release from current grant owner
//               gnt_valid : grant code qualifier
//               gnt_code  : encoded grant index for the decoder
//               timeout   : one-cycle pulse when a grant ended by hold expiry
//               master    : requester side (drives req/rel)
//               slave     : arbiter side (drives grant outputs)
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_select_encoder_if;
    import rr_select_pkg::*;

    logic [N_REQ-1:0] req;
    logic             rel;
    logic             gnt_valid;
    code_t            gnt_code;
    logic             timeout;

    modport master (
        output req,
        output rel,
        input  gnt_valid,
        input  gnt_code,
        input  timeout
    );

    modport slave (
        input  req,
        input  rel,
        output gnt_valid,
        output gnt_code,
        output timeout
    );

endinterface
`default_nettype wire

// File: rtl/rr_select_encoder_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating-priority search. Starting at i_ptr,
//               returns the first index (ptr, ptr+1, ptr+2, ptr+3 mod 4)
//               whose request bit is set.
//               i_req  : request vector
//               i_ptr  : highest-priority index
//               o_pick : selected index (0 when o_any is low)
//               o_any  : at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import rr_select_pkg::*;
(
    input  wire logic [N_REQ-1:0] i_req,
    input  wire code_t            i_ptr,
    output code_t                 o_pick,
    output logic                  o_any
);

    code_t w_idx;
    logic  w_found;

    always_comb begin
        o_pick  = 2'd0;
        w_found = 1'b0;
        w_idx   = 2'd0;
        // Walk the four offsets; the first hit wins and later hits are ignored.
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = i_ptr + 2'(k);
            if (!w_found && i_req[w_idx]) begin
                o_pick  = w_idx;
                w_found = 1'b1;
            end
        end
        o_any = |i_req;
    end

endmodule
`default_nettype wire

// File: rtl/rr_select_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rr_select_encoder
// Description : Four-requester round-robin arbiter producing a registered
//               2-bit select code plus qualifying valid for a downstream
//               2x4 decoder. A grant is held until released, until the
//               owner drops its request, or until MAX_HOLD cycles elapse.
//               clk : clock, rising edge
//               rst : synchronous active-high reset
//               bus : rr_select_encoder_if.slave (req, rel in;
//                     gnt_valid, gnt_code, timeout out)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_select_encoder
    import rr_select_pkg::*;
#(
    parameter int MAX_HOLD = 8
)
(
    input  wire logic             clk,
    input  wire logic             rst,
    rr_select_encoder_if.slave    bus
);

    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    // Counter value seen in the last allowed grant cycle.
    localparam logic [HOLD_W-1:0] c_hold_last =
        HOLD_W'((MAX_HOLD < 1) ? 0 : MAX_HOLD - 1);
    localparam bit c_hold_en = (MAX_HOLD > 0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            r_state_q,     w_state_d;
    logic              r_gnt_valid_q, w_gnt_valid_d;
    code_t             r_gnt_code_q,  w_gnt_code_d;
    logic              r_timeout_q,   w_timeout_d;
    code_t             r_ptr_q,       w_ptr_d;
    logic [HOLD_W-1:0] r_hold_q,      w_hold_d;

    // ------------------------------------------------------------------
    // Rotating priority search
    // ------------------------------------------------------------------
    code_t w_pick;
    logic  w_any;

    rr_pick u_pick (
        .i_req  (bus.req),
        .i_ptr  (r_ptr_q),
        .o_pick (w_pick),
        .o_any  (w_any)
    );

    // ------------------------------------------------------------------
    // Grant termination conditions (only meaningful in GRANT)
    // ------------------------------------------------------------------
    logic w_end_rel;
    logic w_end_drop;
    logic w_end_exp;

    assign w_end_rel  = bus.rel;
    assign w_end_drop = ~bus.req[r_gnt_code_q];
    assign w_end_exp  = c_hold_en && (r_hold_q == c_hold_last);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d     = r_state_q;
        w_gnt_valid_d = r_gnt_valid_q;
        w_gnt_code_d  = r_gnt_code_q;
        w_timeout_d   = 1'b0;
        w_ptr_d       = r_ptr_q;
        w_hold_d      = r_hold_q;

        case (r_state_q)
            IDLE: begin
                if (w_any) begin
                    w_state_d     = GRANT;
                    w_gnt_valid_d = 1'b1;
                    w_gnt_code_d  = w_pick;
                    w_hold_d      = '0;
                end
            end
            GRANT: begin
                if (w_end_rel || w_end_drop || w_end_exp) begin
                    // gnt_code is left as-is; consumers qualify with valid.
                    w_state_d     = IDLE;
                    w_gnt_valid_d = 1'b0;
                    w_ptr_d       = code_inc(r_gnt_code_q);
                    // Expiry only reports when it was the sole reason to end.
                    w_timeout_d   = w_end_exp && !w_end_rel && !w_end_drop;
                end else begin
                    w_hold_d = r_hold_q + HOLD_W'(1);
                end
            end
            default: begin
                w_state_d     = IDLE;
                w_gnt_valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= IDLE;
            r_gnt_valid_q <= 1'b0;
            r_gnt_code_q  <= 2'b00;
            r_timeout_q   <= 1'b0;
            r_ptr_q       <= 2'b00;
            r_hold_q      <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_gnt_valid_q <= w_gnt_valid_d;
            r_gnt_code_q  <= w_gnt_code_d;
            r_timeout_q   <= w_timeout_d;
            r_ptr_q       <= w_ptr_d;
            r_hold_q      <= w_hold_d;
        end
    end

    assign bus.gnt_valid = r_gnt_valid_q;
    assign bus.gnt_code  = r_gnt_code_q;
    assign bus.timeout   = r_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_select_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_select_encoder
// Description : Self-checking bench for rr_select_encoder. Directed scenarios
//               followed by random traffic, each cycle compared against a
//               grant-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_select_encoder;

    localparam int MAX_HOLD = 8;

    logic clk;
    logic rst;

    rr_select_encoder_if bus ();

    rr_select_encoder #(
        .MAX_HOLD (MAX_HOLD)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the bus, for how many cycles, and who is next.
    int m_valid   = 0;
    int m_code    = 0;
    int m_timeout = 0;
    int m_ptr     = 0;
    int m_age     = 0;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic [3:0] r, input logic l, input logic rs);
        bit ended_rel, ended_drop, ended_exp;
        if (rs) begin
            m_valid = 0; m_code = 0; m_timeout = 0; m_ptr = 0; m_age = 0;
        end else if (m_valid == 0) begin
            m_timeout = 0;
            if (r != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (r[(m_ptr + i) % 4]) begin
                        m_code = (m_ptr + i) % 4;
                        break;
                    end
                end
                m_valid = 1;
                m_age   = 1;
            end
        end else begin
            ended_rel  = l;
            ended_drop = !r[m_code];
            ended_exp  = (MAX_HOLD != 0) && (m_age == MAX_HOLD);
            if (ended_rel || ended_drop || ended_exp) begin
                m_valid   = 0;
                m_ptr     = (m_code + 1) % 4;
                m_timeout = (ended_exp && !ended_rel && !ended_drop) ? 1 : 0;
            end else begin
                m_age++;
                m_timeout = 0;
            end
        end
    endtask

    // Apply one cycle of inputs, advance model, compare all outputs.
    task automatic step(input logic [3:0] r, input logic l, input logic rs);
        bus.req = r;
        bus.rel = l;
        rst     = rs;
        @(posedge clk);
        model_update(r, l, rs);
        #1;
        check_eq("gnt_valid", 8'(bus.gnt_valid), 8'(m_valid));
        check_eq("gnt_code",  8'(bus.gnt_code),  8'(m_code));
        check_eq("timeout",   8'(bus.timeout),   8'(m_timeout));
        @(negedge clk);
    endtask

    initial begin
        bus.req = 4'b0000;
        bus.rel = 1'b0;
        rst     = 1'b1;
        @(negedge clk);

        // Reset with all requesting, then first grant goes to index 0.
        step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b1);
        check_eq("rst_valid", 8'(bus.gnt_valid), 8'd0);
        check_eq("rst_code",  8'(bus.gnt_code),  8'd0);
        step(4'b1111, 1'b0, 1'b0);
        check_eq("first_code",  8'(bus.gnt_code),  8'd0);
        check_eq("first_valid", 8'(bus.gnt_valid), 8'd1);

        // Rotation 0 -> 1 -> 2 -> 3 -> 0 with a one-cycle gap each time.
        for (int k = 1; k <= 4; k++) begin
            step(4'b1111, 1'b1, 1'b0);
            check_eq("rot_gap", 8'(bus.gnt_valid), 8'd0);
            step(4'b1111, 1'b0, 1'b0);
            check_eq("rot_code", 8'(bus.gnt_code), 8'(k % 4));
        end
        step(4'b1111, 1'b1, 1'b0);          // ptr -> 1
        step(4'b0100, 1'b0, 1'b0);          // grant 2
        step(4'b0100, 1'b1, 1'b0);          // ptr -> 3

        // Skip and wrap.
        step(4'b0100, 1'b0, 1'b0);
        check_eq("skip_code", 8'(bus.gnt_code), 8'd2);
        step(4'b0100, 1'b1, 1'b0);          // ptr -> 3
        step(4'b1001, 1'b0, 1'b0);
        check_eq("wrap_code3", 8'(bus.gnt_code), 8'd3);
        step(4'b1001, 1'b1, 1'b0);
        step(4'b1001, 1'b0, 1'b0);
        check_eq("wrap_code0", 8'(bus.gnt_code), 8'd0);
        step(4'b0000, 1'b1, 1'b0);          // ptr -> 1

        // Hold expiry: exactly MAX_HOLD cycles, then one timeout pulse.
        for (int k = 0; k < MAX_HOLD; k++) begin
            step(4'b0010, 1'b0, 1'b0);
            check_eq("hold_valid", 8'(bus.gnt_valid), 8'd1);
        end
        step(4'b0010, 1'b0, 1'b0);
        check_eq("exp_valid",   8'(bus.gnt_valid), 8'd0);
        check_eq("exp_timeout", 8'(bus.timeout),   8'd1);
        step(4'b0000, 1'b0, 1'b0);
        check_eq("exp_pulse", 8'(bus.timeout), 8'd0);

        // Release coinciding with expiry: no timeout.
        for (int k = 0; k < MAX_HOLD; k++)
            step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        check_eq("relexp_valid",   8'(bus.gnt_valid), 8'd0);
        check_eq("relexp_timeout", 8'(bus.timeout),   8'd0);

        // Owner withdrawal (ptr is 2 here).
        step(4'b0100, 1'b0, 1'b0);
        check_eq("wd_code", 8'(bus.gnt_code), 8'd2);
        for (int k = 0; k < 3; k++)
            step(4'b0100, 1'b0, 1'b0);
        step(4'b1011, 1'b0, 1'b0);
        check_eq("wd_valid",   8'(bus.gnt_valid), 8'd0);
        check_eq("wd_timeout", 8'(bus.timeout),   8'd0);
        step(4'b1011, 1'b0, 1'b0);
        check_eq("wd_next", 8'(bus.gnt_code), 8'd3);
        step(4'b0000, 1'b1, 1'b0);          // ptr -> 0

        // Mid-grant reset.
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b1);
        check_eq("mrst_valid", 8'(bus.gnt_valid), 8'd0);
        check_eq("mrst_code",  8'(bus.gnt_code),  8'd0);
        step(4'b1111, 1'b0, 1'b0);
        check_eq("mrst_next", 8'(bus.gnt_code), 8'd0);

        // Random traffic: requests mostly persist, occasional release/reset.
        begin
            logic [3:0] r;
            r = 4'($urandom);
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 3) == 0)
                    r = 4'($urandom);
                step(r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
